div_unit: RTL and testbench

- Iterative integer divider for the execute stage, successor of the single-mode radix-2 divider.
- Supports RISC-V DIV/DIVU/REM/REMU selection and a configurable number of quotient bits per cycle.
- Uses valid/ready handshakes on input and output, with a tag that passes through to the result.
- Produces RISC-V-compliant results for divide-by-zero and signed overflow.

---
 rtl/div_unit_pkg.sv | 26 ++
 rtl/div_unit_step.sv | 21 ++
 rtl/div_unit.sv | 240 ++++++++++++++++++++++++
 tb/tb_div_unit.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared types and op-decode helpers for the iterative divider.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'd0,
    OpDivu = 2'd1,
    OpRem  = 2'd2,
    OpRemu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_unit_step #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH:0]   rem_in,
  input  logic                  dividend_bit,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH:0]   rem_out,
  output logic                  quo_bit
);

  logic [DATA_WIDTH+1:0] shifted;
  logic [DATA_WIDTH+1:0] diff;

  assign shifted = {rem_in, dividend_bit};
  assign diff    = shifted - {2'b00, divisor};
  // Non-negative difference (or an overflowed shift) means the divisor fits.
  assign quo_bit = shifted[DATA_WIDTH+1] | ~diff[DATA_WIDTH+1];
  assign rem_out = quo_bit ? diff[DATA_WIDTH:0] : shifted[DATA_WIDTH:0];

endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit with valid/ready handshakes.
// Define DIV_UNIT_RESULT_CACHE_EN to reuse the last result for matching operands.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1,
  parameter int unsigned TAG_WIDTH       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic [1:0]            in_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  busy
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned S    = STEPS_PER_CYCLE;
  localparam int unsigned Iter = W / S;
  localparam int unsigned CntW = (Iter > 1) ? $clog2(Iter) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);
  localparam logic [W-1:0]    MinVal  = {1'b1, {(W-1){1'b0}}};

  div_state_e        state_q, state_d;
  div_op_e           op_q, op_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic              a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [W:0]        rem_q, rem_d;
  logic [W-1:0]      quo_q, quo_d;
  logic [W-1:0]      dsr_q, dsr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]      result_q, result_d;

  div_op_e           in_op_e;
  logic              in_a_neg, in_b_neg, in_div_zero, in_overflow;
  logic [W-1:0]      in_a_mag, in_b_mag, spec_quo, spec_rem;
  logic [W-1:0]      fix_quo, fix_rem;

`ifdef DIV_UNIT_RESULT_CACHE_EN
  logic              c_valid_q, c_valid_d, c_sgn_q, c_sgn_d, cache_hit;
  logic [W-1:0]      c_a_q, c_a_d, c_b_q, c_b_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;
  logic [W-1:0]      a_raw_q, a_raw_d, b_raw_q, b_raw_d;
`endif

  // Restoring step chain, MSB of the remaining dividend bits first.
  logic [W:0]   rem_chain [0:S];
  logic [S-1:0] q_bits;

  assign rem_chain[0] = rem_q;

  for (genvar s = 0; s < S; s++) begin : g_step
    div_unit_step #(
      .DATA_WIDTH(W)
    ) u_step (
      .rem_in      (rem_chain[s]),
      .dividend_bit(quo_q[W-1-s]),
      .divisor     (dsr_q),
      .rem_out     (rem_chain[s+1]),
      .quo_bit     (q_bits[S-1-s])
    );
  end

  always_comb begin
    in_op_e     = div_op_e'(in_op);
    in_a_neg    = is_signed_op(in_op_e) & in_dividend[W-1];
    in_b_neg    = is_signed_op(in_op_e) & in_divisor[W-1];
    in_a_mag    = in_a_neg ? -in_dividend : in_dividend;
    in_b_mag    = in_b_neg ? -in_divisor : in_divisor;
    in_div_zero = (in_divisor == '0);
    in_overflow = is_signed_op(in_op_e) && (in_dividend == MinVal) && (in_divisor == '1);
    spec_quo    = in_div_zero ? '1 : MinVal;
    spec_rem    = in_div_zero ? in_dividend : '0;
    fix_quo     = (a_neg_q ^ b_neg_q) ? -quo_q : quo_q;
    fix_rem     = a_neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end

`ifdef DIV_UNIT_RESULT_CACHE_EN
  assign cache_hit = c_valid_q && (c_a_q == in_dividend) && (c_b_q == in_divisor) &&
                     (c_sgn_q == in_op[0]);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tag_d    = tag_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef DIV_UNIT_RESULT_CACHE_EN
    c_valid_d = c_valid_q;
    c_sgn_d   = c_sgn_q;
    c_a_d     = c_a_q;
    c_b_d     = c_b_q;
    c_quo_d   = c_quo_q;
    c_rem_d   = c_rem_q;
    a_raw_d   = a_raw_q;
    b_raw_d   = b_raw_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d    = in_op_e;
          tag_d   = in_tag;
          a_neg_d = in_a_neg;
          b_neg_d = in_b_neg;
`ifdef DIV_UNIT_RESULT_CACHE_EN
          a_raw_d = in_dividend;
          b_raw_d = in_divisor;
`endif
          if (in_div_zero || in_overflow) begin
            state_d  = StDone;
            result_d = is_rem_op(in_op_e) ? spec_rem : spec_quo;
`ifdef DIV_UNIT_RESULT_CACHE_EN
            c_valid_d = 1'b1;
            c_a_d     = in_dividend;
            c_b_d     = in_divisor;
            c_sgn_d   = in_op[0];
            c_quo_d   = spec_quo;
            c_rem_d   = spec_rem;
`endif
          end
`ifdef DIV_UNIT_RESULT_CACHE_EN
          else if (cache_hit) begin
            state_d  = StDone;
            result_d = is_rem_op(in_op_e) ? c_rem_q : c_quo_q;
          end
`endif
          else begin
            state_d = StCalc;
            rem_d   = '0;
            quo_d   = in_a_mag;
            dsr_d   = in_b_mag;
            cnt_d   = '0;
          end
        end
      end
      StCalc: begin
        // quo_q shifts out dividend bits at the top and collects quotient bits below.
        rem_d = rem_chain[S];
        quo_d = {quo_q[W-S-1:0], q_bits};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d  = StDone;
        result_d = is_rem_op(op_q) ? fix_rem : fix_quo;
`ifdef DIV_UNIT_RESULT_CACHE_EN
        c_valid_d = 1'b1;
        c_a_d     = a_raw_q;
        c_b_d     = b_raw_q;
        c_sgn_d   = op_q[0];
        c_quo_d   = fix_quo;
        c_rem_d   = fix_rem;
`endif
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d = StIdle;
`ifdef DIV_UNIT_RESULT_CACHE_EN
      c_valid_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      tag_q    <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef DIV_UNIT_RESULT_CACHE_EN
      c_valid_q <= 1'b0;
      c_sgn_q   <= 1'b0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_quo_q   <= '0;
      c_rem_q   <= '0;
      a_raw_q   <= '0;
      b_raw_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      tag_q    <= tag_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef DIV_UNIT_RESULT_CACHE_EN
      c_valid_q <= c_valid_d;
      c_sgn_q   <= c_sgn_d;
      c_a_q     <= c_a_d;
      c_b_q     <= c_b_d;
      c_quo_q   <= c_quo_d;
      c_rem_q   <= c_rem_d;
      a_raw_q   <= a_raw_d;
      b_raw_q   <= b_raw_d;
`endif
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: reference results from native SV division.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W     = 32;
  localparam int STEPS = 1;
  localparam int ITER  = W / STEPS;
  localparam int TW    = 5;
  localparam logic [W-1:0] MinV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]  in_dividend, in_divisor, out_result;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  div_unit #(
    .DATA_WIDTH     (W),
    .STEPS_PER_CYCLE(STEPS),
    .TAG_WIDTH      (TW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_dividend(in_dividend),
    .in_divisor (in_divisor),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            lat;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          sgn;
    logic          hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef DIV_UNIT_RESULT_CACHE_EN
  logic         c_valid = 1'b0;
  logic [W-1:0] c_a, c_b;
  logic         c_sgn;
`endif

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [W-1:0] a, b);
    return (b == '0) || (!op[0] && a == MinV && b == '1);
  endfunction

  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, b);
    logic [W-1:0] q, r;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!op[0] && a == MinV && b == '1) begin
      q = MinV;
      r = '0;
    end else if (!op[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, b, input logic [TW-1:0] tag);
    exp_t e;
    e.res = model(op, a, b);
    e.tag = tag;
    e.a   = a;
    e.b   = b;
    e.sgn = op[0];
    e.hit = 1'b0;
`ifdef DIV_UNIT_RESULT_CACHE_EN
    e.hit = !is_special(op, a, b) && c_valid && c_a == a && c_b == b && c_sgn == op[0];
`endif
    e.lat = (is_special(op, a, b) || e.hit) ? 1 : ITER + 2;
    check_eq("in_ready_at_issue", 64'(in_ready), 64'd1);
    in_valid    = 1'b1;
    in_op       = op;
    in_dividend = a;
    in_divisor  = b;
    in_tag      = tag;
    step();
    in_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  // Must be called right after issue(): the current sample is cycle T+1.
  task automatic collect(input string name, input int hold);
    exp_t e;
    int   lat;
    if (exp_q.size() == 0) begin
      check_eq({name, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e   = exp_q.pop_front();
    lat = 1;
    while (!out_valid && lat < ITER + 20) begin
      step();
      lat++;
    end
    check_eq({name, "_valid"}, 64'(out_valid), 64'd1);
    check_eq({name, "_lat"}, 64'(lat), 64'(e.lat));
    check_eq({name, "_result"}, 64'(out_result), 64'(e.res));
    check_eq({name, "_tag"}, 64'(out_tag), 64'(e.tag));
    for (int i = 0; i < hold; i++) begin
      in_valid    = 1'b1;
      in_op       = OpDivu;
      in_dividend = 32'd77;
      in_divisor  = 32'd0;
      in_tag      = ~e.tag;
      step();
      check_eq({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      check_eq({name, "_hold_result"}, 64'(out_result), 64'(e.res));
      check_eq({name, "_hold_tag"}, 64'(out_tag), 64'(e.tag));
      check_eq({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({name, "_idle_valid"}, 64'(out_valid), 64'd0);
    check_eq({name, "_idle_ready"}, 64'(in_ready), 64'd1);
    if (hold > 0) begin
      step();
      check_eq({name, "_no_stray_accept"}, 64'(out_valid | busy), 64'd0);
    end
`ifdef DIV_UNIT_RESULT_CACHE_EN
    if (!e.hit) begin
      c_valid = 1'b1;
      c_a     = e.a;
      c_b     = e.b;
      c_sgn   = e.sgn;
    end
`endif
  endtask

  task automatic cache_clear();
`ifdef DIV_UNIT_RESULT_CACHE_EN
    c_valid = 1'b0;
`endif
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_op       = '0;
    in_dividend = '0;
    in_divisor  = '0;
    in_tag      = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", 64'(out_result), 64'd0);
    check_eq("rst_out_tag", 64'(out_tag), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    issue(OpDivu, 32'd100, 32'd7, 5'd3);     collect("divu_100_7", 0);
    issue(OpRemu, 32'd100, 32'd7, 5'd4);     collect("remu_100_7", 0);
    issue(OpDiv, -32'sd7, 32'd2, 5'd5);      collect("div_m7_2", 0);
    issue(OpRem, -32'sd7, 32'd2, 5'd6);      collect("rem_m7_2", 0);
    issue(OpRem, 32'd7, -32'sd2, 5'd7);      collect("rem_7_m2", 0);
    issue(OpDiv, MinV, 32'hFFFF_FFFF, 5'd8); collect("div_ovf", 0);
    issue(OpRem, MinV, 32'hFFFF_FFFF, 5'd9); collect("rem_ovf", 0);
    issue(OpDivu, 32'd5, 32'd0, 5'd10);      collect("divu_by0", 0);
    issue(OpRem, -32'sd5, 32'd0, 5'd11);     collect("rem_by0", 0);
    issue(OpDiv, 32'd1234, -32'sd5, 5'd12);  collect("backpressure", 10);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      issue(rop, ra, rb, 5'(i + 16));
      collect("random", 0);
    end

    // Flush in the tenth CALC cycle discards the operation.
    issue(OpDivu, 32'd100, 32'd7, 5'd13);
    repeat (9) step();
    check_eq("calc_busy", 64'(busy), 64'd1);
    check_eq("calc_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    void'(exp_q.pop_back());
    cache_clear();
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);
    check_eq("flush_in_ready", 64'(in_ready), 64'd1);
    step();
    check_eq("flush_stays_idle", 64'(out_valid | busy), 64'd0);
    issue(OpDivu, 32'd9, 32'd3, 5'd14);      collect("after_flush", 0);

    // Reset while DONE drops the result.
    issue(OpRem, -32'sd5, 32'd0, 5'd15);
    check_eq("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    void'(exp_q.pop_back());
    cache_clear();
    check_eq("rst_done_valid", 64'(out_valid), 64'd0);
    check_eq("rst_done_result", 64'(out_result), 64'd0);
    check_eq("rst_done_ready", 64'(in_ready), 64'd1);

    // Cache sequence; latencies come from the bench's cache model.
    flush = 1'b1;
    step();
    flush = 1'b0;
    cache_clear();
    issue(OpDiv, 32'd1000, 32'd7, 5'd1);     collect("c_div_1000_7", 0);
    issue(OpRem, 32'd1000, 32'd7, 5'd2);     collect("c_rem_1000_7", 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    cache_clear();
    issue(OpRem, 32'd1000, 32'd7, 5'd3);     collect("c_rem_after_flush", 0);
    issue(OpDiv, 32'd1000, 32'd7, 5'd4);     collect("c_div_again", 0);
    issue(OpDivu, 32'd1000, 32'd7, 5'd5);    collect("c_divu_miss", 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
